// File: rtl/dataflow_branch_reg.sv
// Registered N-way outlet switch with a 2-entry skid buffer for valid/ready streams.
// Optional broadcast delivery is enabled with `define DATAFLOW_BRANCH_BROADCAST_EN.
module dataflow_branch_reg #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_OUTPUTS  = 2,
  parameter int unsigned SELECT_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [SELECT_WIDTH-1:0] i_select,
  input  logic                    i_valid,
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
  input  logic                    i_broadcast,
`endif
  output logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [NUM_OUTPUTS-1:0]  o_valid,
  input  logic [NUM_OUTPUTS-1:0]  o_ready
);

  logic                    out_v, out_v_nxt, sk_v, sk_v_nxt;
  logic [DATA_WIDTH-1:0]   out_d, out_d_nxt, sk_d, sk_d_nxt;
  logic [SELECT_WIDTH-1:0] out_s, out_s_nxt, sk_s, sk_s_nxt;
  logic                    in_fire, out_ok, sel_rdy;

`ifdef DATAFLOW_BRANCH_BROADCAST_EN
  logic                   out_b, out_b_nxt, sk_b, sk_b_nxt;
  logic [NUM_OUTPUTS-1:0] done, done_nxt, done_acc;
`endif

  // Upstream ready comes straight from the skid flag, never from o_ready.
  assign i_ready = ~sk_v;
  assign in_fire = i_valid & i_ready;
  assign o_data  = out_d;

  // Per-channel valid decode; broadcast items target every channel not yet served.
  always_comb begin
    o_valid = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      o_valid[k] = out_v && (out_s == SELECT_WIDTH'(k));
    end
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
    if (out_b) begin
      o_valid = {NUM_OUTPUTS{out_v}} & ~done;
    end
`endif
  end

  // Retire condition; an out-of-range select finds no ready bit and retires at once.
  always_comb begin
    sel_rdy = 1'b1;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      if (out_s == SELECT_WIDTH'(k)) begin
        sel_rdy = o_ready[k];
      end
    end
    out_ok = out_v & sel_rdy;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
    done_acc = done | (o_valid & o_ready);
    if (out_b) begin
      out_ok = out_v & (&done_acc);
    end
`endif
  end

  // Next-state for the output and skid stages.
  always_comb begin
    out_v_nxt = out_v;
    out_d_nxt = out_d;
    out_s_nxt = out_s;
    sk_v_nxt  = sk_v;
    sk_d_nxt  = sk_d;
    sk_s_nxt  = sk_s;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
    out_b_nxt = out_b;
    sk_b_nxt  = sk_b;
    done_nxt  = (out_v && out_b && !out_ok) ? done_acc : '0;
`endif
    if (!out_v || out_ok) begin
      if (sk_v) begin
        out_v_nxt = 1'b1;
        out_d_nxt = sk_d;
        out_s_nxt = sk_s;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
        out_b_nxt = sk_b;
`endif
        sk_v_nxt  = 1'b0;
      end else if (in_fire) begin
        out_v_nxt = 1'b1;
        out_d_nxt = i_data;
        out_s_nxt = i_select;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
        out_b_nxt = i_broadcast;
`endif
      end else begin
        out_v_nxt = 1'b0;
      end
    end else if (in_fire) begin
      sk_v_nxt = 1'b1;
      sk_d_nxt = i_data;
      sk_s_nxt = i_select;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
      sk_b_nxt = i_broadcast;
`endif
    end
  end

  // Control state with synchronous reset; in-flight items are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v <= 1'b0;
      sk_v  <= 1'b0;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
      done  <= '0;
`endif
    end else begin
      out_v <= out_v_nxt;
      sk_v  <= sk_v_nxt;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
      done  <= done_nxt;
`endif
    end
  end

  // Payload registers carry no reset; they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    out_d <= out_d_nxt;
    out_s <= out_s_nxt;
    sk_d  <= sk_d_nxt;
    sk_s  <= sk_s_nxt;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
    out_b <= out_b_nxt;
    sk_b  <= sk_b_nxt;
`endif
  end

endmodule

// File: tb/tb_dataflow_branch_reg.sv
// Scoreboard bench for dataflow_branch_reg: a 4-way instance for streaming, stall,
// reset and random traffic, and a 3-way instance for the out-of-range select case.
module tb_dataflow_branch_reg;
  localparam int unsigned DW  = 16;
  localparam int unsigned NA  = 4;
  localparam int unsigned SWA = 3;
  localparam int unsigned NB  = 3;
  localparam int unsigned SWB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [DW-1:0]  a_idata, a_odata;
  logic [SWA-1:0] a_isel;
  logic           a_ivalid, a_iready;
  logic [NA-1:0]  a_ovalid, a_ordy;
  logic [DW-1:0]  b_idata, b_odata;
  logic [SWB-1:0] b_isel;
  logic           b_ivalid, b_iready;
  logic [NB-1:0]  b_ovalid, b_ordy;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
  logic a_bcast, b_bcast;
`endif

  dataflow_branch_reg #(.DATA_WIDTH(DW), .NUM_OUTPUTS(NA), .SELECT_WIDTH(SWA)) dut_a (
    .clk(clk), .reset(reset), .i_data(a_idata), .i_select(a_isel), .i_valid(a_ivalid),
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
    .i_broadcast(a_bcast),
`endif
    .i_ready(a_iready), .o_data(a_odata), .o_valid(a_ovalid), .o_ready(a_ordy));

  dataflow_branch_reg #(.DATA_WIDTH(DW), .NUM_OUTPUTS(NB), .SELECT_WIDTH(SWB)) dut_b (
    .clk(clk), .reset(reset), .i_data(b_idata), .i_select(b_isel), .i_valid(b_ivalid),
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
    .i_broadcast(b_bcast),
`endif
    .i_ready(b_iready), .o_data(b_odata), .o_valid(b_ovalid), .o_ready(b_ordy));

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [SWA-1:0] s;
    int unsigned    acc;
    logic           lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  logic        mon_en = 1'b0;
  logic        rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every output handshake must match the oldest outstanding expected item.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("onehot_valid", 32'($countones(a_ovalid) <= 1), 32'd1);
      for (int k = 0; k < NA; k++) begin
        if (a_ovalid[k] && a_ordy[k]) begin
          if (sb.size() == 0) begin
            check("unexpected_item", 32'(k) | 32'h100, 32'h0);
          end else begin
            e = sb.pop_front();
            check("channel", 32'(k), 32'(e.s));
            check("data", 32'(a_odata), 32'(e.d));
            if (e.lat) check("latency_cycle", cyc, e.acc);
          end
        end
      end
    end
  end

  // Random consumer readiness; also flips o_ready mid-cycle to show i_ready ignores it.
  always @(posedge clk) begin
    logic ir;
    if (rnd_rdy) begin
      #1 a_ordy = NA'($urandom);
      #1 ir = a_iready;
      a_ordy = ~a_ordy;
      #1 check("iready_indep_of_oready", 32'(a_iready), 32'(ir));
      a_ordy = ~a_ordy;
    end
  end

  task automatic drive(input logic [DW-1:0] d, input logic [SWA-1:0] s);
    a_ivalid = 1'b1;
    a_idata  = d;
    a_isel   = s;
  endtask

  // Holds the current offer until accepted; in-range items enter the scoreboard.
  task automatic wait_accept(input logic lat, input int unsigned budget, output int unsigned waited);
    logic got;
    got = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      if (a_iready) begin
        got = 1'b1;
        if (32'(a_isel) < NA) sb.push_back('{d: a_idata, s: a_isel, acc: cyc + 1, lat: lat});
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_within_budget", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [SWA-1:0] s, input logic lat,
                      output int unsigned waited);
    drive(d, s);
    wait_accept(lat, 200, waited);
  endtask

  task automatic idle_cycle();
    a_ivalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    a_ivalid = 1'b0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    int unsigned sent;
    logic [SWA-1:0] rs;
    reset = 1'b1;
    a_ivalid = 1'b0; a_idata = '0; a_isel = '0; a_ordy = '1;
    b_ivalid = 1'b0; b_idata = '0; b_isel = '0; b_ordy = '1;
`ifdef DATAFLOW_BRANCH_BROADCAST_EN
    a_bcast = 1'b0; b_bcast = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ovalid_a", 32'(a_ovalid), 32'h0);
    check("reset_iready_a", 32'(a_iready), 32'h1);
    check("reset_ovalid_b", 32'(b_ovalid), 32'h0);
    check("reset_iready_b", 32'(b_iready), 32'h1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: back-to-back items, each accepted at once and delivered next cycle.
    for (int n = 0; n < 8; n++) begin
      send(DW'(16'h100 + n), SWA'(n % 4), 1'b1, w);
      check("stream_no_wait", w, 32'd0);
    end
    drain();

    // Stall/skid: A blocks on channel 2, B fills skid, C is held until A drains.
    a_ordy = 4'b1011;
    send(16'hA0A0, 3'd2, 1'b0, w);
    check("stall_a_accept", w, 32'd0);
    send(16'hB0B0, 3'd0, 1'b0, w);
    check("stall_b_accept", w, 32'd0);
    drive(16'hC0C0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("skid_full_iready", 32'(a_iready), 32'h0);
      check("stalled_head_valid", 32'(a_ovalid), 32'h4);
      @(posedge clk);
      #1;
    end
    a_ordy = 4'b1111;
    wait_accept(1'b0, 50, w);
    drain();

    // Out-of-range select on the 4-way instance is swallowed without any o_valid.
    send(16'hDEAD, 3'd5, 1'b0, w);
    a_ivalid = 1'b0;
    @(negedge clk);
    check("oor_a_no_valid", 32'(a_ovalid), 32'h0);
    @(posedge clk);
    #1;
    send(16'h0011, 3'd1, 1'b1, w);
    drain();

    // Out-of-range on the 3-way instance; the following item shows up one cycle later.
    b_ivalid = 1'b1; b_idata = 16'hDEAD; b_isel = 2'd3;
    @(negedge clk);
    check("oor_b_accept", 32'(b_iready), 32'h1);
    @(posedge clk);
    #1 b_idata = 16'h0011; b_isel = 2'd1;
    @(negedge clk);
    check("oor_b_dropped", 32'(b_ovalid), 32'h0);
    check("oor_b_next_accept", 32'(b_iready), 32'h1);
    @(posedge clk);
    #1 b_ivalid = 1'b0;
    @(negedge clk);
    check("oor_b_next_valid", 32'(b_ovalid), 32'h2);
    check("oor_b_next_data", 32'(b_odata), 32'h0011);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("oor_b_idle", 32'(b_ovalid), 32'h0);
    @(posedge clk);
    #1;

    // Reset with both stages full drops everything; next item has 1-cycle latency.
    a_ordy = 4'b0000;
    send(16'h1111, 3'd0, 1'b0, w);
    send(16'h2222, 3'd1, 1'b0, w);
    a_ivalid = 1'b0;
    @(negedge clk);
    check("full_iready_low", 32'(a_iready), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("post_reset_ovalid", 32'(a_ovalid), 32'h0);
    check("post_reset_iready", 32'(a_iready), 32'h1);
    @(posedge clk);
    #1 a_ordy = 4'b1111;
    send(16'h3333, 3'd2, 1'b1, w);
    drain();

`ifdef DATAFLOW_BRANCH_BROADCAST_EN
    // Broadcast: channels retire in groups; item leaves after the last handshake.
    mon_en = 1'b0;
    a_ordy = 4'b0011;
    a_bcast = 1'b1;
    drive(16'h0055, 3'd0);
    @(negedge clk);
    check("bc_accept", 32'(a_iready), 32'h1);
    @(posedge clk);
    #1 a_ivalid = 1'b0; a_bcast = 1'b0;
    @(negedge clk);
    check("bc_valid_1111", 32'(a_ovalid), 32'hF);
    check("bc_data", 32'(a_odata), 32'h0055);
    @(posedge clk);
    #1 a_ordy = 4'b0100;
    @(negedge clk);
    check("bc_valid_1100", 32'(a_ovalid), 32'hC);
    @(posedge clk);
    #1 a_ordy = 4'b1000;
    @(negedge clk);
    check("bc_valid_1000", 32'(a_ovalid), 32'h8);
    @(posedge clk);
    #1 a_ordy = 4'b1111;
    @(negedge clk);
    check("bc_valid_0000", 32'(a_ovalid), 32'h0);
    @(posedge clk);
    #1 mon_en = 1'b1;
`endif

    // Random traffic: random offers, random per-channel readiness, occasional bad selects.
    rnd_rdy = 1'b1;
    sent = 0;
    while (sent < 2000) begin
      if ($urandom_range(0, 1) == 1) begin
        rs = ($urandom_range(0, 7) == 0) ? SWA'(4 + $urandom_range(0, 3)) : SWA'($urandom_range(0, 3));
        send(DW'($urandom), rs, 1'b0, w);
        sent++;
      end else begin
        idle_cycle();
      end
    end
    a_ivalid = 1'b0;
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #4 a_ordy = 4'b1111;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
